// File: rtl/slot_index_pkg.sv
// Shared definitions for the slot index encoder: the zero-counter direction
// constants and the index-width helper used by the interface and the RTL.
package slot_index_pkg;

  // Zero-counter scan direction.
  localparam int LZC_TRAILING = 0;
  localparam int LZC_LEADING  = 1;

  // Width of an index into a vector of n bits. A 1-bit vector still gets a
  // 1-bit index so that no port collapses to zero width.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/slot_index_encoder_if.sv
// Bus bundle of the slot index encoder. The master drives the input vectors
// and valid; the slave (the encoder) returns the registered results.
interface slot_index_encoder_if
  import slot_index_pkg::*;
#(
  parameter int WIDTH = 8
);

  localparam int IDX_W = idx_width(WIDTH);

  logic             valid_i;
  logic [WIDTH-1:0] lz_in_i;
  logic [WIDTH-1:0] oh_in_i;
  logic             valid_o;
  logic [IDX_W-1:0] cnt_o;
  logic             empty_o;
  logic [IDX_W-1:0] bin_o;
  logic             oh_err_o;

  modport master (
    output valid_i, lz_in_i, oh_in_i,
    input  valid_o, cnt_o, empty_o, bin_o, oh_err_o
  );

  modport slave (
    input  valid_i, lz_in_i, oh_in_i,
    output valid_o, cnt_o, empty_o, bin_o, oh_err_o
  );

endinterface

// File: rtl/zero_count_tree.sv
// Combinational trailing/leading zero counter built as a binary priority
// tree. Leading-zero mode mirrors the input so both modes share one
// trailing-zero tree. cnt is forced to 0 when the input is all zero.
module zero_count_tree
  import slot_index_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = LZC_TRAILING
) (
  input  logic [WIDTH-1:0]            in_vec,
  output logic [idx_width(WIDTH)-1:0] cnt,
  output logic                        empty
);

  localparam int IDX_W = idx_width(WIDTH);
  localparam int LEAVES = 1 << IDX_W;

  logic [LEAVES-1:0] scan;
  logic              node_v   [IDX_W+1][LEAVES];
  logic [IDX_W-1:0]  node_idx [IDX_W+1][LEAVES];

  // Map the input onto the leaves: bit-reverse for leading-zero mode and
  // pad the unused leaves up to the next power of two with zeros.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment, otherwise unassigned paths infer latches.
    scan = '0;
    for (int i = 0; i < WIDTH; i++) begin
      scan[i] = (MODE == LZC_LEADING) ? in_vec[WIDTH-1-i] : in_vec[i];
    end
  end

  // Reduce pairs level by level; the lower child wins, and the winner's
  // side contributes one index bit per level.
  always_comb begin
    for (int l = 0; l <= IDX_W; l++) begin
      for (int i = 0; i < LEAVES; i++) begin
        node_v[l][i]   = 1'b0;
        node_idx[l][i] = '0;
      end
    end
    for (int i = 0; i < LEAVES; i++) begin
      node_v[0][i] = scan[i];
    end
    for (int l = 0; l < IDX_W; l++) begin
      for (int j = 0; j < (LEAVES >> (l + 1)); j++) begin
        node_v[l+1][j] = node_v[l][2*j] | node_v[l][2*j+1];
        if (node_v[l][2*j]) begin
          node_idx[l+1][j] = node_idx[l][2*j];
        end else begin
          node_idx[l+1][j] = node_idx[l][2*j+1] | (IDX_W'(1) << l);
        end
      end
    end
  end

  // Root of the tree; an empty input reports a count of zero.
  always_comb begin
    empty = ~node_v[IDX_W][0];
    cnt   = empty ? '0 : node_idx[IDX_W][0];
  end

endmodule

// File: rtl/slot_index_encoder.sv
// Registered index encoder for the AXI guard tables: a configurable
// trailing/leading zero counter (first free slot) and a one-hot-to-binary
// encoder (ID match to table index), both registered once for a fixed
// 1-cycle latency.
// Optional feature: define SLOT_INDEX_ENCODER_ONEHOT_CHECK_EN to register a
// multi-hot flag on oh_err_o (and raise $error in simulation); otherwise
// oh_err_o is tied to 0.
module slot_index_encoder
  import slot_index_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = LZC_TRAILING
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  slot_index_encoder_if.slave  bus
);

  localparam int IDX_W = idx_width(WIDTH);

  if (WIDTH < 1 || (MODE != LZC_TRAILING && MODE != LZC_LEADING)) begin : g_bad_cfg
    $fatal(1, "slot_index_encoder: illegal WIDTH=%0d or MODE=%0d", WIDTH, MODE);
  end

  logic [IDX_W-1:0] cnt_c;
  logic             empty_c;
  logic [IDX_W-1:0] bin_c;

  zero_count_tree #(
    .WIDTH (WIDTH),
    .MODE  (MODE)
  ) u_zero_count_tree (
    .in_vec (bus.lz_in_i),
    .cnt    (cnt_c),
    .empty  (empty_c)
  );

  // One-hot to binary: OR together the index of every set bit, so a
  // multi-hot input yields a defined (if meaningless) index.
  always_comb begin
    bin_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.oh_in_i[i]) begin
        bin_c = bin_c | IDX_W'(i);
      end
    end
  end

  // Output registers: valid follows valid_i every cycle, data only loads on
  // a valid input and otherwise holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      bus.valid_o <= 1'b0;
      bus.cnt_o   <= '0;
      bus.empty_o <= 1'b0;
      bus.bin_o   <= '0;
    end else begin
      bus.valid_o <= bus.valid_i;
      if (bus.valid_i) begin
        bus.cnt_o   <= cnt_c;
        bus.empty_o <= empty_c;
        bus.bin_o   <= bin_c;
      end
    end
  end

`ifdef SLOT_INDEX_ENCODER_ONEHOT_CHECK_EN
  logic oh_multi_c;

  // More than one bit set in the match vector.
  always_comb begin
    oh_multi_c = ($countones(bus.oh_in_i) > 1);
  end

  // Multi-hot flag register, loaded alongside the data registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus.oh_err_o <= 1'b0;
    end else if (bus.valid_i) begin
      bus.oh_err_o <= oh_multi_c;
    end
  end

`ifndef SYNTHESIS
  // Simulation-only report of a multi-hot match vector.
  always @(posedge clk_i) begin
    if (rst_ni && bus.valid_i) begin
      assert (!oh_multi_c)
      else $error("slot_index_encoder: oh_in_i 0x%0h is not one-hot", bus.oh_in_i);
    end
  end
`endif
`else
  assign bus.oh_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_slot_index_encoder.sv
// Self-checking bench for slot_index_encoder. Three instances share clock,
// reset and stimulus: WIDTH=8 trailing, WIDTH=8 leading and WIDTH=1. Each
// output is compared every cycle against a behavioural model of the
// registered outputs.
module tb_slot_index_encoder;
  import slot_index_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;

  always #5 clk_i = ~clk_i;

  slot_index_encoder_if #(.WIDTH(8)) if_t ();
  slot_index_encoder_if #(.WIDTH(8)) if_l ();
  slot_index_encoder_if #(.WIDTH(1)) if_w1 ();

  slot_index_encoder #(.WIDTH(8), .MODE(LZC_TRAILING)) dut_t (
    .clk_i (clk_i), .rst_ni (rst_ni), .bus (if_t)
  );
  slot_index_encoder #(.WIDTH(8), .MODE(LZC_LEADING)) dut_l (
    .clk_i (clk_i), .rst_ni (rst_ni), .bus (if_l)
  );
  slot_index_encoder #(.WIDTH(1), .MODE(LZC_TRAILING)) dut_w1 (
    .clk_i (clk_i), .rst_ni (rst_ni), .bus (if_w1)
  );

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SLOT_INDEX_ENCODER_ONEHOT_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  // Model state per instance: 0 = W8 trailing, 1 = W8 leading, 2 = W1.
  int exp_valid [3];
  int exp_cnt   [3];
  int exp_empty [3];
  int exp_bin   [3];
  int exp_err   [3];

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Number of zeros before the first set bit, scanning from bit 0 upward
  // (trailing) or from the top bit downward (leading); 0 for an empty vector.
  function automatic int ref_cnt(input logic [7:0] v, input int w, input bit leading);
    for (int k = 0; k < w; k++) begin
      if (v[leading ? (w - 1 - k) : k]) return k;
    end
    return 0;
  endfunction

  function automatic int ref_bin(input logic [7:0] v, input int w);
    int r = 0;
    for (int k = 0; k < w; k++) if (v[k]) r = r | k;
    return r;
  endfunction

  function automatic int ref_ones(input logic [7:0] v, input int w);
    int n = 0;
    for (int k = 0; k < w; k++) if (v[k]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      exp_valid[d] = 0; exp_cnt[d] = 0; exp_empty[d] = 0;
      exp_bin[d] = 0;   exp_err[d] = 0;
    end
  endtask

  task automatic model_capture(input int d, input logic v, input logic [7:0] lz,
                               input logic [7:0] oh, input int w, input bit leading);
    exp_valid[d] = v;
    if (v) begin
      exp_cnt[d]   = ref_cnt(lz, w, leading);
      exp_empty[d] = (ref_ones(lz, w) == 0);
      exp_bin[d]   = ref_bin(oh, w);
      exp_err[d]   = CHECK_EN ? int'(ref_ones(oh, w) > 1) : 0;
    end
  endtask

  task automatic check_all(input string phase);
    check({phase, " t.valid"}, int'(if_t.valid_o),  exp_valid[0]);
    check({phase, " t.cnt"},   int'(if_t.cnt_o),    exp_cnt[0]);
    check({phase, " t.empty"}, int'(if_t.empty_o),  exp_empty[0]);
    check({phase, " t.bin"},   int'(if_t.bin_o),    exp_bin[0]);
    check({phase, " t.err"},   int'(if_t.oh_err_o), exp_err[0]);
    check({phase, " l.valid"}, int'(if_l.valid_o),  exp_valid[1]);
    check({phase, " l.cnt"},   int'(if_l.cnt_o),    exp_cnt[1]);
    check({phase, " l.empty"}, int'(if_l.empty_o),  exp_empty[1]);
    check({phase, " l.bin"},   int'(if_l.bin_o),    exp_bin[1]);
    check({phase, " l.err"},   int'(if_l.oh_err_o), exp_err[1]);
    check({phase, " w1.valid"}, int'(if_w1.valid_o),  exp_valid[2]);
    check({phase, " w1.cnt"},   int'(if_w1.cnt_o),    exp_cnt[2]);
    check({phase, " w1.empty"}, int'(if_w1.empty_o),  exp_empty[2]);
    check({phase, " w1.bin"},   int'(if_w1.bin_o),    exp_bin[2]);
    check({phase, " w1.err"},   int'(if_w1.oh_err_o), exp_err[2]);
  endtask

  task automatic drive(input logic v, input logic [7:0] lz, input logic [7:0] oh);
    if_t.valid_i  = v; if_t.lz_in_i  = lz;   if_t.oh_in_i  = oh;
    if_l.valid_i  = v; if_l.lz_in_i  = lz;   if_l.oh_in_i  = oh;
    if_w1.valid_i = v; if_w1.lz_in_i = lz[0]; if_w1.oh_in_i = oh[0];
  endtask

  // Drive one input cycle, then check the registered results just after
  // the capturing edge.
  task automatic step(input string phase, input logic v, input logic [7:0] lz,
                      input logic [7:0] oh);
    @(negedge clk_i);
    drive(v, lz, oh);
    @(posedge clk_i);
    #1;
    model_capture(0, v, lz, oh, 8, 1'b0);
    model_capture(1, v, lz, oh, 8, 1'b1);
    model_capture(2, v, lz, oh, 1, 1'b0);
    check_all(phase);
  endtask

  function automatic logic [7:0] rand_lz();
    logic [7:0] r = 8'($urandom);
    return ($urandom_range(0, 3) == 0) ? 8'h00 : r;
  endfunction

  function automatic logic [7:0] rand_oh(input bit allow_multi);
    int sel = $urandom_range(0, 3);
    logic [7:0] r = 8'($urandom);
    if (sel == 0) return 8'h00;
    if (sel == 3 && allow_multi) return r;
    return 8'h01 << $urandom_range(0, 7);
  endfunction

  initial begin
    logic [7:0] oh_v;
    rst_ni = 1'b0;
    drive(1'b0, 8'h00, 8'h00);
    model_reset();
    #12;
    check_all("reset");

    // Release reset between edges; an idle cycle must leave outputs at 0.
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("idle", 1'b0, 8'hFF, 8'hFF);

    // Directed cases.
    step("tz", 1'b1, 8'b0110_1000, 8'b0000_0000);
    step("lz", 1'b1, 8'b0010_0001, 8'b0000_0001);
    step("zero", 1'b1, 8'b0000_0000, 8'b0000_0000);
    step("top", 1'b1, 8'b1000_0000, 8'b1000_0000);
    for (int i = 0; i < 8; i++) begin
      oh_v = 8'h01 << i;
      step("sweep", 1'b1, 8'h01 << (7 - i), oh_v);
    end
    step("multi", 1'b1, 8'b0000_0001, 8'b0001_0100);
    step("hold", 1'b0, 8'b0000_0000, 8'b1111_1111);
    step("hold2", 1'b0, 8'b0101_0101, 8'b0000_0010);

    // Randomised traffic with idle gaps.
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), rand_lz(), rand_oh(!CHECK_EN));
    end

    // Reset asserted between edges must clear the outputs immediately.
    step("pre_rst", 1'b1, 8'b0001_0000, 8'b0100_0000);
    @(negedge clk_i);
    drive(1'b1, 8'b0000_0110, 8'b0000_1000);
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk_i);
    #1;
    check_all("in_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 50; i++) begin
      step("post_rst", ($urandom_range(0, 1) != 0), rand_lz(), rand_oh(!CHECK_EN));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
